// File: rtl/cache_pkg.sv
// Shared types and address-field helpers for the n-way write-back data cache.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        REFILL,
        FLUSH
    } cache_state_e;

    function automatic int unsigned idx_bits(input int unsigned sets);
        return $clog2(sets);
    endfunction

    function automatic int unsigned tag_bits(input int unsigned data_w, input int unsigned sets);
        return data_w - 2 - $clog2(sets);
    endfunction

    function automatic int unsigned way_bits(input int unsigned ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/cache_tag_array.sv
// One way of tag/valid/dirty state with its hit comparator; a single index serves lookup and update.
module cache_tag_array
    import cache_pkg::*;
#(
    parameter  int unsigned SETS  = 16,
    parameter  int unsigned TAG_W = 26,
    localparam int unsigned IDX_W = idx_bits(SETS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] idx,
    input  logic [TAG_W-1:0] tag,
    input  logic             install,
    input  logic             set_dirty,
    input  logic             clr_dirty,
    output logic             hit_c,
    output logic             valid_c,
    output logic             dirty_c,
    output logic [TAG_W-1:0] tag_c
);

    logic [SETS-1:0]  valid_q;
    logic [SETS-1:0]  dirty_q;
    logic [TAG_W-1:0] tag_q [SETS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (install) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (set_dirty) begin
            dirty_q[idx] <= 1'b1;
        end else if (clr_dirty) begin
            dirty_q[idx] <= 1'b0;
        end
    end

    // Tags carry no meaning until valid is set, so they are never reset.
    always_ff @(posedge clk) begin
        if (install) begin
            tag_q[idx] <= tag;
        end
    end

    assign valid_c = valid_q[idx];
    assign dirty_c = dirty_q[idx];
    assign tag_c   = tag_q[idx];
    assign hit_c   = valid_q[idx] && (tag_q[idx] == tag);

endmodule

// File: rtl/data_cache_nway.sv
// N-way set-associative, one-word-line, write-back/write-allocate data cache with flush.
module data_cache_nway
    import cache_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SETS   = 16,
    parameter int unsigned WAYS   = 2
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [DATA_W-1:0] Addr,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] Data,
    output logic              Hit,
    input  logic              Flush,
    output logic              FlushDone,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              memory_ready
);

    localparam int unsigned IDX_W = idx_bits(SETS);
    localparam int unsigned TAG_W = tag_bits(DATA_W, SETS);
    localparam int unsigned WAY_W = way_bits(WAYS);

    cache_state_e      state_q, state_d;
    logic [IDX_W-1:0]  a_idx, miss_idx_q, scan_set_q, cur_idx;
    logic [TAG_W-1:0]  a_tag, miss_tag_q, cur_tag;
    logic [WAY_W-1:0]  victim_q, victim_c, hit_way_c, scan_way_q;
    logic [WAY_W-1:0]  rr_ptr [SETS];
    logic              flush_pend_q;
    logic [WAYS-1:0]   hit_vec, valid_vec, dirty_vec;
    logic [TAG_W-1:0]  tag_vec [WAYS];
    logic [DATA_W-1:0] data_mem [WAYS][SETS];
    logic              access_c, hit_any_c, miss_c, install_c, store_hit_c;
    logic              clr_dirty_c, scan_step_c, scan_last_c, flush_go_c;
    logic              unused_addr_bits;

    assign a_idx            = Addr[2 +: IDX_W];
    assign a_tag            = Addr[DATA_W-1 -: TAG_W];
    assign unused_addr_bits = ^Addr[1:0];
    assign access_c         = MemRead | MemWrite;
    assign scan_last_c      = (scan_set_q == IDX_W'(SETS - 1)) && (scan_way_q == WAY_W'(WAYS - 1));

    // During a miss the arrays are addressed by the captured miss, not the live Addr.
    always_comb begin
        cur_idx = miss_idx_q;
        cur_tag = miss_tag_q;
        if (state_q == IDLE) begin
            cur_idx = a_idx;
            cur_tag = a_tag;
        end else if (state_q == FLUSH) begin
            cur_idx = scan_set_q;
        end
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        cache_tag_array #(.SETS(SETS), .TAG_W(TAG_W)) u_tag (
            .clk       (CLK),
            .rst_n     (Reset),
            .idx       (cur_idx),
            .tag       (cur_tag),
            .install   (install_c && (victim_q == WAY_W'(w))),
            .set_dirty (store_hit_c && (hit_way_c == WAY_W'(w))),
            .clr_dirty (clr_dirty_c && (scan_way_q == WAY_W'(w))),
            .hit_c     (hit_vec[w]),
            .valid_c   (valid_vec[w]),
            .dirty_c   (dirty_vec[w]),
            .tag_c     (tag_vec[w])
        );
    end

    // Hit encode and victim choice: lowest invalid way, else the set's round-robin pointer.
    always_comb begin
        hit_any_c = 1'b0;
        hit_way_c = '0;
        victim_c  = rr_ptr[a_idx];
        for (int w = 0; w < WAYS; w++) begin
            if (hit_vec[w]) begin
                hit_any_c = 1'b1;
                hit_way_c = WAY_W'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_vec[w]) begin
                victim_c = WAY_W'(w);
            end
        end
    end

    assign Hit  = !Reset || ((state_q == IDLE) && (!access_c || hit_any_c));
    assign Data = data_mem[hit_way_c][a_idx];

    always_comb begin
        state_d     = state_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        miss_c      = 1'b0;
        install_c   = 1'b0;
        store_hit_c = 1'b0;
        clr_dirty_c = 1'b0;
        scan_step_c = 1'b0;
        flush_go_c  = 1'b0;
        unique case (state_q)
            IDLE: begin
                store_hit_c = MemWrite && hit_any_c;
                if (access_c && !hit_any_c) begin
                    miss_c  = 1'b1;
                    state_d = (valid_vec[victim_c] && dirty_vec[victim_c]) ? WRITEBACK : REFILL;
                end else if (flush_pend_q || Flush) begin
                    flush_go_c = 1'b1;
                    state_d    = FLUSH;
                end
            end
            WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tag_vec[victim_q], miss_idx_q, 2'b00};
                mem_wdata = data_mem[victim_q][miss_idx_q];
                if (memory_ready) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {miss_tag_q, miss_idx_q, 2'b00};
                if (memory_ready) begin
                    install_c = 1'b1;
                    state_d   = IDLE;
                end
            end
            FLUSH: begin
                if (valid_vec[scan_way_q] && dirty_vec[scan_way_q]) begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = {tag_vec[scan_way_q], scan_set_q, 2'b00};
                    mem_wdata = data_mem[scan_way_q][scan_set_q];
                    if (memory_ready) begin
                        clr_dirty_c = 1'b1;
                        scan_step_c = 1'b1;
                    end
                end else begin
                    scan_step_c = 1'b1;
                end
                if (scan_step_c && scan_last_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q      <= IDLE;
            flush_pend_q <= 1'b0;
            FlushDone    <= 1'b0;
            scan_set_q   <= '0;
            scan_way_q   <= '0;
            victim_q     <= '0;
            miss_idx_q   <= '0;
            miss_tag_q   <= '0;
            for (int s = 0; s < SETS; s++) begin
                rr_ptr[s] <= '0;
            end
        end else begin
            state_q   <= state_d;
            FlushDone <= scan_step_c && scan_last_c;
            if (flush_go_c) begin
                flush_pend_q <= 1'b0;
            end else if (Flush && (state_q != FLUSH)) begin
                flush_pend_q <= 1'b1;
            end
            if (miss_c) begin
                miss_idx_q <= a_idx;
                miss_tag_q <= a_tag;
                victim_q   <= victim_c;
            end
            if (install_c) begin
                rr_ptr[miss_idx_q] <= (rr_ptr[miss_idx_q] == WAY_W'(WAYS - 1)) ? '0
                                    : rr_ptr[miss_idx_q] + WAY_W'(1);
            end
            // Scan wraps back to set 0 / way 0 after the last line, ready for the next flush.
            if (scan_step_c) begin
                if (scan_way_q == WAY_W'(WAYS - 1)) begin
                    scan_way_q <= '0;
                    scan_set_q <= scan_set_q + IDX_W'(1);
                end else begin
                    scan_way_q <= scan_way_q + WAY_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (install_c) begin
            data_mem[victim_q][miss_idx_q] <= mem_rdata;
        end else if (store_hit_c) begin
            data_mem[hit_way_c][a_idx] <= WriteData;
        end
    end

endmodule
